// File: rtl/mont_stream_io.sv
// Word-stream front/back end for the 1024-bit montgomery multiplier.
// Optional REDUCE step (conditional subtract of M) under MONT_IO_CONDSUB_EN.
module mont_stream_io #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [OP_W-1:0]   mont_a,
    output logic [OP_W-1:0]   mont_b,
    output logic [OP_W-1:0]   mont_m,
    output logic              mont_start,
    input  logic [OP_W-1:0]   mont_result,
    input  logic              mont_done,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy
);

    localparam int NW = OP_W / WORD_W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_M,
        S_START,
        S_WAIT,
        S_DRAIN
`ifdef MONT_IO_CONDSUB_EN
        , S_REDUCE
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]                r_cnt;
    logic [NW-1:0][WORD_W-1:0]    r_a;
    logic [NW-1:0][WORD_W-1:0]    r_b;
    logic [NW-1:0][WORD_W-1:0]    r_m;
    logic [OP_W-1:0]              r_sh;

    logic w_in_fire;
    logic w_out_fire;
    logic w_cnt_last;

`ifdef MONT_IO_CONDSUB_EN
    logic [OP_W-1:0] w_diff;
    logic            w_ge;

    assign w_diff = r_sh - mont_m;
    assign w_ge   = (r_sh >= mont_m);
`endif

    assign w_in_fire  = s_valid && s_ready;
    assign w_out_fire = m_valid && m_ready;
    assign w_cnt_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_LOAD_A: if (w_in_fire && w_cnt_last) w_next = S_LOAD_B;
            S_LOAD_B: if (w_in_fire && w_cnt_last) w_next = S_LOAD_M;
            S_LOAD_M: if (w_in_fire && w_cnt_last) w_next = S_START;
            S_START:  w_next = S_WAIT;
            S_WAIT: begin
                if (mont_done) begin
`ifdef MONT_IO_CONDSUB_EN
                    w_next = S_REDUCE;
`else
                    w_next = S_DRAIN;
`endif
                end
            end
`ifdef MONT_IO_CONDSUB_EN
            S_REDUCE: w_next = S_DRAIN;
`endif
            S_DRAIN:  if (w_out_fire && w_cnt_last) w_next = S_LOAD_A;
            default:  w_next = S_LOAD_A;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        mont_start = 1'b0;
        m_valid    = 1'b0;
        unique case (r_state)
            S_LOAD_A, S_LOAD_B, S_LOAD_M: s_ready = 1'b1;
            S_START:  mont_start = 1'b1;
            S_DRAIN:  m_valid = 1'b1;
            default: ;
        endcase
    end

    assign m_last = m_valid && w_cnt_last;
    assign m_data = r_sh[WORD_W-1:0];
    assign busy   = !((r_state == S_LOAD_A) && (r_cnt == '0));
    assign mont_a = r_a;
    assign mont_b = r_b;
    assign mont_m = r_m;

    // one counter serves both the load and the drain phases
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_m   <= '0;
            r_sh  <= '0;
        end else begin
            if (w_in_fire || w_out_fire) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            end
            if (w_in_fire) begin
                unique case (r_state)
                    S_LOAD_A: r_a[r_cnt] <= s_data;
                    S_LOAD_B: r_b[r_cnt] <= s_data;
                    S_LOAD_M: r_m[r_cnt] <= s_data;
                    default: ;
                endcase
            end
            if ((r_state == S_WAIT) && mont_done) begin
                r_sh <= mont_result;
            end
`ifdef MONT_IO_CONDSUB_EN
            if ((r_state == S_REDUCE) && w_ge) begin
                r_sh <= w_diff;
            end
`endif
            if (w_out_fire) begin
                r_sh <= {{WORD_W{1'b0}}, r_sh[OP_W-1:WORD_W]};
            end
        end
    end

endmodule

// File: tb/tb_mont_stream_io.sv
// Randomized bench for mont_stream_io with a 7-cycle multiplier stub
// and an arithmetic reference model of the whole operation.
module tb_mont_stream_io;

    localparam int W      = 32;
    localparam int OW     = 1024;
    localparam int NW     = 32;
    localparam int BUDGET = 3000;
`ifdef MONT_IO_CONDSUB_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic [OW-1:0] mont_a;
    logic [OW-1:0] mont_b;
    logic [OW-1:0] mont_m;
    logic          mont_start;
    logic [OW-1:0] mont_result;
    logic          mont_done;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;

    always #5 clk = ~clk;

    mont_stream_io #(.WORD_W(W), .OP_W(OW)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_start(mont_start),
        .mont_result(mont_result), .mont_done(mont_done),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy)
    );

    // multiplier stub: result is only meaningful while done is high
    logic [3:0]    stub_cnt;
    int            stub_sel = 0;
    bit            inj_start = 1'b0;
    logic [OW-1:0] stub_good;

    always @(posedge clk) begin
        if (reset) stub_cnt <= 4'd0;
        else if (mont_start) stub_cnt <= 4'd7;
        else if (stub_cnt != 4'd0) stub_cnt <= stub_cnt - 4'd1;
    end

    assign stub_good = (stub_sel == 0) ? (mont_a ^ mont_b) :
                       (stub_sel == 1) ? (mont_m + 1024'd5) :
                                         (mont_m - 1024'd1);
    assign mont_result = (stub_cnt == 4'd1) ? stub_good : ~stub_good;
    assign mont_done = (stub_cnt == 4'd1) || (inj_start && mont_start);

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0]  in_q[$];
    logic [W-1:0]  out_q[$];
    logic          last_q[$];
    logic [OW-1:0] snap_a;
    int n_start, overlap_err, hold_err, busy_err;
    int acc, ci, cs, fv, cl, c97;

    function automatic logic [OW-1:0] model(input logic [OW-1:0] a,
                                            input logic [OW-1:0] b,
                                            input logic [OW-1:0] m,
                                            input int sel);
        logic [OW-1:0] r;
        if (sel == 0) r = a ^ b;
        else if (sel == 1) r = m + 1024'd5;
        else r = m - 1024'd1;
`ifdef MONT_IO_CONDSUB_EN
        if (r >= m) r = r - m;
`endif
        return r;
    endfunction

    function automatic logic [OW-1:0] rand_op();
        logic [OW-1:0] v;
        for (int i = 0; i < NW; i++) v[W*i +: W] = $urandom;
        return v;
    endfunction

    function automatic logic [W-1:0] get_out(input int i);
        if (i < out_q.size()) return out_q[i];
        return 'x;
    endfunction

    function automatic logic get_last(input int i);
        if (i < last_q.size()) return last_q[i];
        return 1'bx;
    endfunction

    task automatic push_op(input logic [OW-1:0] a,
                           input logic [OW-1:0] b,
                           input logic [OW-1:0] m);
        for (int i = 0; i < NW; i++) in_q.push_back(a[W*i +: W]);
        for (int i = 0; i < NW; i++) in_q.push_back(b[W*i +: W]);
        for (int i = 0; i < NW; i++) in_q.push_back(m[W*i +: W]);
    endtask

    // mode 0: m_ready high, 1: toggling, 2: random
    task automatic run(input int nout, input int mode, output int to);
        int  cyc;
        bit  hold_pend;
        logic [W-1:0] hold_d;
        logic hold_l;
        bit  bexp;
        cyc = 0; hold_pend = 0; hold_d = '0; hold_l = 0;
        out_q.delete(); last_q.delete();
        n_start = 0; overlap_err = 0; hold_err = 0; busy_err = 0;
        acc = 0; ci = -1; cs = -1; fv = -1; cl = -1; c97 = -1;
        while ((in_q.size() != 0 || out_q.size() < nout) && cyc < BUDGET) begin
            @(negedge clk);
            if (s_ready && m_valid) overlap_err++;
            if (mont_start) begin
                n_start++;
                cs = cyc;
                snap_a = mont_a;
            end
            if (m_valid && fv < 0) fv = cyc;
            if (hold_pend && (m_data !== hold_d || m_last !== hold_l)) hold_err++;
            bexp = !((acc % (3*NW) == 0) && (out_q.size() == (acc / (3*NW)) * NW));
            if (busy !== bexp) busy_err++;
            s_valid = (in_q.size() != 0);
            s_data = s_valid ? in_q[0] : $urandom;
            if (mode == 0) m_ready = 1'b1;
            else if (mode == 1) m_ready = (cyc % 2 == 0);
            else m_ready = 1'($urandom_range(0, 1));
            hold_pend = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            if (s_valid && s_ready) begin
                acc++;
                ci = cyc;
                if (acc == 3*NW + 1) c97 = cyc;
                void'(in_q.pop_front());
            end
            if (m_valid && m_ready) begin
                out_q.push_back(m_data);
                last_q.push_back(m_last);
                if (m_last && cl < 0) cl = cyc;
            end
            cyc++;
        end
        to = (cyc >= BUDGET) ? 1 : 0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        in_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_ready got %b want 1", s_ready); end
        n_vec++; if (mont_start !== 1'b0) begin n_err++; $display("FAIL rst_start got %b want 0", mont_start); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
        n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_m_last got %b want 0", m_last); end
        n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL rst_m_data got %h want 0", m_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if ((mont_a | mont_b | mont_m) !== '0) begin n_err++; $display("FAIL rst_operands not zero"); end
    endtask

    task automatic test_directed(input int mode, input string tag);
        logic [OW-1:0] a, b, m, r;
        int to;
        for (int i = 0; i < NW; i++) begin
            a[W*i +: W] = W'(i + 1);
            b[W*i +: W] = 32'hFFFF_FFFF;
            m[W*i +: W] = 32'h8000_0000;
        end
        r = model(a, b, m, 0);
        stub_sel = 0;
        push_op(a, b, m);
        run(NW, mode, to);
        n_vec++; if (to !== 0) begin n_err++; $display("FAIL %s_timeout got %0d want 0", tag, to); end
        n_vec++; if (n_start !== 1) begin n_err++; $display("FAIL %s_starts got %0d want 1", tag, n_start); end
        n_vec++; if (snap_a[31:0] !== 32'h1) begin n_err++; $display("FAIL %s_a_lo got %h want 1", tag, snap_a[31:0]); end
        n_vec++; if (snap_a[1023:992] !== 32'h20) begin n_err++; $display("FAIL %s_a_hi got %h want 20", tag, snap_a[1023:992]); end
        n_vec++; if (overlap_err !== 0) begin n_err++; $display("FAIL %s_overlap got %0d want 0", tag, overlap_err); end
        n_vec++; if (hold_err !== 0) begin n_err++; $display("FAIL %s_hold got %0d want 0", tag, hold_err); end
        n_vec++; if (out_q.size() !== NW) begin n_err++; $display("FAIL %s_count got %0d want %0d", tag, out_q.size(), NW); end
        for (int i = 0; i < NW; i++) begin
            n_vec++;
            if (get_out(i) !== r[W*i +: W]) begin
                n_err++; $display("FAIL %s_word%0d got %h want %h", tag, i, get_out(i), r[W*i +: W]);
            end
            n_vec++;
            if (get_last(i) !== (i == NW - 1)) begin
                n_err++; $display("FAIL %s_last%0d got %b want %b", tag, i, get_last(i), i == NW - 1);
            end
        end
    endtask

    task automatic test_done_in_start();
        logic [OW-1:0] a, b, m, r;
        int to;
        a = rand_op(); b = rand_op(); m = rand_op();
        r = model(a, b, m, 0);
        stub_sel = 0; inj_start = 1'b1;
        push_op(a, b, m);
        run(NW, 2, to);
        inj_start = 1'b0;
        n_vec++; if (to !== 0) begin n_err++; $display("FAIL dis_timeout got %0d want 0", to); end
        n_vec++; if (n_start !== 1) begin n_err++; $display("FAIL dis_starts got %0d want 1", n_start); end
        n_vec++; if (cs - ci !== 1) begin n_err++; $display("FAIL dis_start_lat got %0d want 1", cs - ci); end
        n_vec++; if (fv - cs !== LAT) begin n_err++; $display("FAIL dis_valid_lat got %0d want %0d", fv - cs, LAT); end
        n_vec++; if (hold_err !== 0) begin n_err++; $display("FAIL dis_hold got %0d want 0", hold_err); end
        n_vec++; if (busy_err !== 0) begin n_err++; $display("FAIL dis_busy got %0d want 0", busy_err); end
        for (int i = 0; i < NW; i++) begin
            n_vec++;
            if (get_out(i) !== r[W*i +: W]) begin
                n_err++; $display("FAIL dis_word%0d got %h want %h", i, get_out(i), r[W*i +: W]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] a, b, m, r;
        int to;
        for (int i = 0; i < 40; i++) in_q.push_back($urandom);
        run(0, 0, to);
        n_vec++; if (to !== 0) begin n_err++; $display("FAIL rm_part_timeout got %0d want 0", to); end
        n_vec++; if (n_start !== 0) begin n_err++; $display("FAIL rm_part_starts got %0d want 0", n_start); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_busy_pre got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy_post got %b want 0", busy); end
        n_vec++; if (mont_start !== 1'b0) begin n_err++; $display("FAIL rm_start got %b want 0", mont_start); end
        n_vec++; if (mont_a !== '0) begin n_err++; $display("FAIL rm_a_cleared got %h want 0", mont_a[31:0]); end
        a = rand_op(); b = rand_op(); m = rand_op();
        r = model(a, b, m, 0);
        stub_sel = 0;
        push_op(a, b, m);
        run(NW, 2, to);
        n_vec++; if (to !== 0) begin n_err++; $display("FAIL rm_timeout got %0d want 0", to); end
        n_vec++; if (n_start !== 1) begin n_err++; $display("FAIL rm_starts got %0d want 1", n_start); end
        for (int i = 0; i < NW; i++) begin
            n_vec++;
            if (get_out(i) !== r[W*i +: W]) begin
                n_err++; $display("FAIL rm_word%0d got %h want %h", i, get_out(i), r[W*i +: W]);
            end
        end
    endtask

    task automatic test_condsub(input int sel, input string tag);
        logic [OW-1:0] a, b, m, r;
        int to;
        a = rand_op(); b = rand_op(); m = rand_op();
        m[OW-1] = 1'b0;
        m[0] = 1'b1;
        r = model(a, b, m, sel);
        stub_sel = sel;
        push_op(a, b, m);
        run(NW, 0, to);
        stub_sel = 0;
        n_vec++; if (to !== 0) begin n_err++; $display("FAIL %s_timeout got %0d want 0", tag, to); end
`ifdef MONT_IO_CONDSUB_EN
        if (sel == 1) begin
            n_vec++;
            if (get_out(0) !== 32'h5) begin n_err++; $display("FAIL %s_w0 got %h want 5", tag, get_out(0)); end
        end
`endif
        for (int i = 0; i < NW; i++) begin
            n_vec++;
            if (get_out(i) !== r[W*i +: W]) begin
                n_err++; $display("FAIL %s_word%0d got %h want %h", tag, i, get_out(i), r[W*i +: W]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] a0, b0, m0, a1, b1, m1, r0, r1;
        int to;
        a0 = rand_op(); b0 = rand_op(); m0 = rand_op();
        a1 = rand_op(); b1 = rand_op(); m1 = rand_op();
        r0 = model(a0, b0, m0, 0);
        r1 = model(a1, b1, m1, 0);
        stub_sel = 0;
        push_op(a0, b0, m0);
        push_op(a1, b1, m1);
        run(2*NW, 0, to);
        n_vec++; if (to !== 0) begin n_err++; $display("FAIL b2b_timeout got %0d want 0", to); end
        n_vec++; if (n_start !== 2) begin n_err++; $display("FAIL b2b_starts got %0d want 2", n_start); end
        n_vec++; if (c97 - cl !== 1) begin n_err++; $display("FAIL b2b_gap got %0d want 1", c97 - cl); end
        n_vec++; if (busy_err !== 0) begin n_err++; $display("FAIL b2b_busy got %0d want 0", busy_err); end
        n_vec++; if (overlap_err !== 0) begin n_err++; $display("FAIL b2b_overlap got %0d want 0", overlap_err); end
        for (int i = 0; i < 2*NW; i++) begin
            logic [W-1:0] e;
            e = (i < NW) ? r0[W*i +: W] : r1[W*(i-NW) +: W];
            n_vec++;
            if (get_out(i) !== e) begin
                n_err++; $display("FAIL b2b_word%0d got %h want %h", i, get_out(i), e);
            end
            n_vec++;
            if (get_last(i) !== (i % NW == NW - 1)) begin
                n_err++; $display("FAIL b2b_last%0d got %b want %b", i, get_last(i), i % NW == NW - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed(0, "dir");
        test_directed(1, "tog");
        test_done_in_start();
        test_reset_mid();
        test_condsub(1, "mp5");
        test_condsub(2, "mm1");
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
